// File: rtl/udma_filter_bincu_if.sv
// Stream bundle for the binarising filter: the upstream sample stream and
// the downstream result stream. The filter is the slave on both; the
// environment (DMA source and rx data-out stage) is the master.
interface udma_filter_bincu_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] input_data_i;
    logic                  input_valid_i;
    logic                  input_ready_o;
    logic [DATA_WIDTH-1:0] output_data_o;
    logic                  output_valid_o;
    logic                  output_ready_i;

    modport slave (
        input  input_data_i,
        input  input_valid_i,
        output input_ready_o,
        output output_data_o,
        output output_valid_o,
        input  output_ready_i
    );

    modport master (
        output input_data_i,
        output input_valid_i,
        input  input_ready_o,
        input  output_data_o,
        input  output_valid_o,
        output output_ready_i
    );
endinterface

// File: rtl/udma_filter_bincu.sv
// Binarising threshold filter: each accepted sample is compared against a
// threshold and the 1-bit result is optionally forwarded downstream. A hit
// counter can raise a one-cycle event every cfg_counter hits.
module udma_filter_bincu #(
    parameter int DATA_WIDTH = 32,
    parameter int TRANS_SIZE = 16
) (
    input  logic                  clk_i,
    input  logic                  resetn_i,
    input  logic                  cmd_start_i,
    output logic                  cmd_done_o,
    input  logic [1:0]            cfg_datasize_i,
    input  logic                  cfg_use_signed_i,
    input  logic                  cfg_out_enable_i,
    input  logic                  cfg_en_counter_i,
    input  logic [DATA_WIDTH-1:0] cfg_threshold_i,
    input  logic [TRANS_SIZE-1:0] cfg_len_i,
    input  logic [TRANS_SIZE-1:0] cfg_counter_i,
    output logic [TRANS_SIZE-1:0] counter_val_o,
    output logic                  act_event_o,
    udma_filter_bincu_if.slave    stream
);

    typedef enum logic {ST_IDLE, ST_RUN} state_e;

    state_e                state_q, state_d;

    // Configuration captured at start; the live cfg_* inputs are ignored afterwards.
    logic [1:0]            r_datasize;
    logic                  r_signed;
    logic                  r_out_en;
    logic                  r_en_cnt;
    logic [DATA_WIDTH-1:0] r_threshold;
    logic [TRANS_SIZE-1:0] r_len;
    logic [TRANS_SIZE-1:0] r_target;

    logic [TRANS_SIZE-1:0] r_idx;
    logic [TRANS_SIZE-1:0] r_count;
    logic                  r_event;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;

    logic                  start;
    logic                  in_ready;
    logic                  accept;
    logic                  last_beat;
    logic [DATA_WIDTH-1:0] operand;
    logic                  hit;

    assign start = (state_q == ST_IDLE) && cmd_start_i;

    // State register.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) state_q <= ST_IDLE;
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        else           state_q <= state_d;
    end

    // Next state, input back-pressure, acceptance and the done pulse.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch.
        state_d   = state_q;
        in_ready  = 1'b0;
        accept    = 1'b0;
        last_beat = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                in_ready  = r_out_en ? (!r_out_valid || stream.output_ready_i) : 1'b1;
                accept    = stream.input_valid_i && in_ready;
                last_beat = accept && (r_idx == r_len);
                if (last_beat) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand extraction from the low bits of the sample and threshold compare.
    always_comb begin
        operand = stream.input_data_i;
        case (r_datasize)
            2'b00:   operand = r_signed ? {{(DATA_WIDTH-8){stream.input_data_i[7]}}, stream.input_data_i[7:0]}
                                        : {{(DATA_WIDTH-8){1'b0}}, stream.input_data_i[7:0]};
            2'b01:   operand = r_signed ? {{(DATA_WIDTH-16){stream.input_data_i[15]}}, stream.input_data_i[15:0]}
                                        : {{(DATA_WIDTH-16){1'b0}}, stream.input_data_i[15:0]};
            default: operand = stream.input_data_i;
        endcase
        hit = r_signed ? ($signed(operand) > $signed(r_threshold)) : (operand > r_threshold);
    end

    // Configuration latch on the idle start pulse.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_datasize  <= '0;
            r_signed    <= 1'b0;
            r_out_en    <= 1'b0;
            r_en_cnt    <= 1'b0;
            r_threshold <= '0;
            r_len       <= '0;
            r_target    <= '0;
        end else if (start) begin
            r_datasize  <= cfg_datasize_i;
            r_signed    <= cfg_use_signed_i;
            r_out_en    <= cfg_out_enable_i;
            r_en_cnt    <= cfg_en_counter_i;
            r_threshold <= cfg_threshold_i;
            r_len       <= cfg_len_i;
            r_target    <= cfg_counter_i;
        end
    end

    // Sample index, hit counter and the registered hit-target event.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_idx   <= '0;
            r_count <= '0;
            r_event <= 1'b0;
        end else begin
            r_event <= 1'b0;
            if (start) begin
                r_idx   <= '0;
                r_count <= '0;
            end else if (accept) begin
                r_idx <= last_beat ? '0 : r_idx + TRANS_SIZE'(1);
                if (hit) begin
                    if (r_en_cnt && (r_target != '0) && (r_count == r_target - TRANS_SIZE'(1))) begin
                        r_count <= '0;
                        r_event <= 1'b1;
                    end else begin
                        r_count <= r_count + TRANS_SIZE'(1);
                    end
                end
            end
        end
    end

    // One-entry output register; load and drain in the same cycle keeps full rate.
    always_ff @(posedge clk_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
        end else if (accept && r_out_en) begin
            r_out_valid <= 1'b1;
            r_out_data  <= {{(DATA_WIDTH-1){1'b0}}, hit};
        end else if (stream.output_ready_i) begin
            r_out_valid <= 1'b0;
        end
    end

    assign stream.input_ready_o  = in_ready;
    assign stream.output_valid_o = r_out_valid;
    assign stream.output_data_o  = r_out_data;
    assign cmd_done_o            = last_beat;
    assign counter_val_o         = r_count;
    assign act_event_o           = r_event;

endmodule

// File: tb/tb_udma_filter_bincu.sv
// Directed bench for udma_filter_bincu: stimulus pushes expected results into
// a queue, a monitor pops and compares on every downstream transfer.
module tb_udma_filter_bincu;

    localparam int DW = 32;
    localparam int TS = 16;

    logic          clk;
    logic          resetn;
    logic          cmd_start;
    logic          cmd_done;
    logic [1:0]    cfg_datasize;
    logic          cfg_use_signed;
    logic          cfg_out_enable;
    logic          cfg_en_counter;
    logic [DW-1:0] cfg_threshold;
    logic [TS-1:0] cfg_len;
    logic [TS-1:0] cfg_counter;
    logic [TS-1:0] counter_val;
    logic          act_event;

    udma_filter_bincu_if #(.DATA_WIDTH(DW)) bus ();

    udma_filter_bincu #(.DATA_WIDTH(DW), .TRANS_SIZE(TS)) dut (
        .clk_i            (clk),
        .resetn_i         (resetn),
        .cmd_start_i      (cmd_start),
        .cmd_done_o       (cmd_done),
        .cfg_datasize_i   (cfg_datasize),
        .cfg_use_signed_i (cfg_use_signed),
        .cfg_out_enable_i (cfg_out_enable),
        .cfg_en_counter_i (cfg_en_counter),
        .cfg_threshold_i  (cfg_threshold),
        .cfg_len_i        (cfg_len),
        .cfg_counter_i    (cfg_counter),
        .counter_val_o    (counter_val),
        .act_event_o      (act_event),
        .stream           (bus)
    );

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW-1:0] sb_q[$];
    logic          cur_out_en = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one pop per completed downstream transfer.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.output_valid_o && bus.output_ready_i) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL out_unexpected: got 0x%0h expected no beat", bus.output_data_o);
                end else begin
                    check("out_data", bus.output_data_o, sb_q.pop_front());
                end
            end
        end
    end

    task automatic start_cmd(input logic [1:0] ds, input logic sgn, input logic oen, input logic ecnt,
                             input logic [DW-1:0] thr, input logic [TS-1:0] len, input logic [TS-1:0] tgt);
        cmd_start      = 1'b1;
        cfg_datasize   = ds;
        cfg_use_signed = sgn;
        cfg_out_enable = oen;
        cfg_en_counter = ecnt;
        cfg_threshold  = thr;
        cfg_len        = len;
        cfg_counter    = tgt;
        cur_out_en     = oen;
        @(posedge clk); #1;
        cmd_start = 1'b0;
        // Scramble live configuration: the block must keep its latched copy.
        cfg_datasize   = ~ds;
        cfg_use_signed = ~sgn;
        cfg_out_enable = ~oen;
        cfg_en_counter = ~ecnt;
        cfg_threshold  = ~thr;
        cfg_len        = ~len;
        cfg_counter    = ~tgt;
        check("count_after_start", counter_val, 0);
    endtask

    // Present one sample, wait (bounded) for acceptance, then check done,
    // the registered event and the output-valid latency.
    task automatic send(input logic [DW-1:0] d, input logic exp_hit, input logic exp_ev,
                        input logic last, output int waits);
        logic ok;
        ok    = 1'b0;
        waits = 0;
        bus.input_valid_i = 1'b1;
        bus.input_data_i  = d;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            if (bus.input_ready_o) begin
                ok = 1'b1;
                break;
            end
            waits++;
        end
        if (!ok) begin
            check("accept_timeout", 0, 1);
            bus.input_valid_i = 1'b0;
            @(posedge clk); #1;
            return;
        end
        check("done", cmd_done, last);
        if (cur_out_en) sb_q.push_back({31'b0, exp_hit});
        @(posedge clk); #1;
        bus.input_valid_i = 1'b0;
        check("event", act_event, exp_ev);
        check("out_valid_latency", bus.output_valid_o, cur_out_en);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    int w;

    initial begin
        resetn             = 1'b0;
        cmd_start          = 1'b0;
        cfg_datasize       = '0;
        cfg_use_signed     = 1'b0;
        cfg_out_enable     = 1'b0;
        cfg_en_counter     = 1'b0;
        cfg_threshold      = '0;
        cfg_len            = '0;
        cfg_counter        = '0;
        bus.input_data_i   = '0;
        bus.input_valid_i  = 1'b0;
        bus.output_ready_i = 1'b1;

        // Reset state.
        #22;
        check("rst_out_valid", bus.output_valid_o, 0);
        check("rst_out_data", bus.output_data_o, 0);
        check("rst_in_ready", bus.input_ready_o, 0);
        check("rst_count", counter_val, 0);
        check("rst_event", act_event, 0);
        check("rst_done", cmd_done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        check("idle_in_ready", bus.input_ready_o, 0);

        // Unsigned byte, threshold 0x10, four samples; counter target 0 never fires.
        start_cmd(2'b00, 1'b0, 1'b1, 1'b1, 32'h10, 16'd3, 16'd0);
        send(32'h0000_000F, 1'b0, 1'b0, 1'b0, w);
        send(32'h0000_0010, 1'b0, 1'b0, 1'b0, w);
        send(32'h0000_0011, 1'b1, 1'b0, 1'b0, w);
        send(32'h0000_00FF, 1'b1, 1'b0, 1'b1, w);
        check("t1_count", counter_val, 2);
        idle(3);
        check("t1_idle_in_ready", bus.input_ready_o, 0);

        // Signed byte vs 0 with junk in the upper bits, then the unsigned view.
        start_cmd(2'b00, 1'b1, 1'b1, 1'b0, 32'h0, 16'd1, 16'd0);
        send(32'hABCD_EF80, 1'b0, 1'b0, 1'b0, w);
        send(32'h1234_567F, 1'b1, 1'b0, 1'b1, w);
        idle(2);
        start_cmd(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 16'd1, 16'd0);
        send(32'hABCD_EF80, 1'b1, 1'b0, 1'b0, w);
        send(32'h1234_567F, 1'b1, 1'b0, 1'b1, w);
        idle(2);

        // Unsigned half with a 5-cycle downstream stall after the first beat.
        start_cmd(2'b01, 1'b0, 1'b1, 1'b0, 32'h100, 16'd3, 16'd0);
        send(32'h0000_0101, 1'b1, 1'b0, 1'b0, w);
        bus.output_ready_i = 1'b0;
        bus.input_valid_i  = 1'b1;
        bus.input_data_i   = 32'h0000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", bus.input_ready_o, 0);
            check("stall_out_valid", bus.output_valid_o, 1);
            check("stall_out_data", bus.output_data_o, 1);
        end
        @(posedge clk); #1;
        bus.output_ready_i = 1'b1;
        send(32'h0000_0100, 1'b0, 1'b0, 1'b0, w);
        check("b2b_wait1", w, 0);
        send(32'h0000_FFFF, 1'b1, 1'b0, 1'b0, w);
        check("b2b_wait2", w, 0);
        send(32'h1234_0005, 1'b0, 1'b0, 1'b1, w);
        check("b2b_wait3", w, 0);
        check("t3_count", counter_val, 2);
        idle(2);

        // Hit counter with target 2: events after hits 2 and 4.
        start_cmd(2'b10, 1'b0, 1'b1, 1'b1, 32'd5, 16'd4, 16'd2);
        send(32'd100, 1'b1, 1'b0, 1'b0, w);
        send(32'd100, 1'b1, 1'b1, 1'b0, w);
        send(32'd100, 1'b1, 1'b0, 1'b0, w);
        send(32'd100, 1'b1, 1'b1, 1'b0, w);
        send(32'd100, 1'b1, 1'b0, 1'b1, w);
        check("t4_count", counter_val, 1);
        idle(2);

        // Sink mode, signed half vs 0x10, eight samples back-to-back.
        start_cmd(2'b01, 1'b1, 1'b0, 1'b0, 32'h10, 16'd7, 16'd0);
        send(32'h0000_0011, 1'b1, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_0010, 1'b0, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_FFFF, 1'b0, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_7FFF, 1'b1, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_8000, 1'b0, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_0005, 1'b0, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'hFFFF_0020, 1'b1, 1'b0, 1'b0, w); check("sink_wait", w, 0);
        send(32'h0000_0000, 1'b0, 1'b0, 1'b1, w); check("sink_wait", w, 0);
        check("t5_count", counter_val, 3);
        idle(2);

        // Reset mid-transfer with an output pending, then a single-sample run.
        start_cmd(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 16'd3, 16'd0);
        send(32'h05, 1'b1, 1'b0, 1'b0, w);
        send(32'h06, 1'b1, 1'b0, 1'b0, w);
        bus.output_ready_i = 1'b0;
        #1;
        check("pre_rst_pending", bus.output_valid_o, 1);
        resetn = 1'b0;
        #1;
        sb_q.delete();
        check("mid_rst_out_valid", bus.output_valid_o, 0);
        check("mid_rst_out_data", bus.output_data_o, 0);
        check("mid_rst_in_ready", bus.input_ready_o, 0);
        check("mid_rst_count", counter_val, 0);
        check("mid_rst_event", act_event, 0);
        check("mid_rst_done", cmd_done, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk); #1;
        bus.output_ready_i = 1'b1;
        start_cmd(2'b00, 1'b0, 1'b1, 1'b0, 32'h0, 16'd0, 16'd0);
        send(32'h01, 1'b1, 1'b0, 1'b1, w);
        idle(4);
        check("post_rst_idle_in_ready", bus.input_ready_o, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/udma_filter_bincu.md
UDMA_FILTER_BINCU -- requirements
Module: udma_filter_bincu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, sample and output data width.
REQ-002 SHALL have parameter TRANS_SIZE, default 16, width of the length, counter-target and count fields.
REQ-003 SHALL have port clk_i  in  1  the single clock; one clock, no other clock domains.
REQ-004 SHALL have port resetn_i  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port cmd_start_i  in  1  start pulse; configuration is sampled on this pulse.
REQ-006 SHALL have port cmd_done_o  out  1  one-cycle pulse when the last sample is accepted.
REQ-007 SHALL have port cfg_datasize_i  in  2  input sample size: 00 byte, 01 half, 10 word, 11 word.
REQ-008 SHALL have port cfg_use_signed_i  in  1  1 selects a signed compare with sign extension.
REQ-009 SHALL have port cfg_out_enable_i  in  1  1 forwards binary results downstream; 0 makes the block a sink.
REQ-010 SHALL have port cfg_en_counter_i  in  1  enables the hit-count event.
REQ-011 SHALL have port cfg_threshold_i  in  DATA_WIDTH  compare threshold.
REQ-012 SHALL have port cfg_len_i  in  TRANS_SIZE  sample count minus 1.
REQ-013 SHALL have port cfg_counter_i  in  TRANS_SIZE  hit-count event target.
REQ-014 SHALL have port counter_val_o  out  TRANS_SIZE  current hit count.
REQ-015 SHALL have port act_event_o  out  1  one-cycle pulse when the hit target is reached.
REQ-016 SHALL have port input_data_i / input_valid_i / input_ready_o  in/in/out  DATA_WIDTH/1/1  upstream sample stream.
REQ-017 SHALL have port output_data_o / output_valid_o / output_ready_i  out/out/in  DATA_WIDTH/1/1  result stream feeding the rx data-out stage.

Function
REQ-018 SHALL have two FSM states, IDLE and RUN; IDLE->RUN on cmd_start_i; RUN->IDLE in the cycle the last sample (index cfg_len_i) is accepted; cmd_start_i in RUN is ignored.
REQ-019 SHALL latch all cfg_* inputs on the IDLE cmd_start_i cycle, clear the sample index and hit count, and use only latched values until the next start.
REQ-020 SHALL treat an input beat as accepted when input_valid_i && input_ready_o.
REQ-021 SHALL hold input_ready_o = 0 in IDLE.
REQ-022 SHALL drive input_ready_o in RUN as follows: (!r_out_valid || output_ready_i) with out_enable=1; 1 with out_enable=0.
REQ-023 SHALL extract the compared operand from the low bits of the sample: byte bits 7:0, half bits 15:0, word the full word; zero-extended when unsigned, sign-extended when signed.
REQ-024 SHALL define hit as operand > threshold, with a signed or unsigned compare per cfg_use_signed; equal is not a hit.
REQ-025 SHALL use a one-entry output register: on acceptance with out_enable=1, output_data_o <= {0…, hit} and output_valid_o <= 1 in the next cycle (latency 1).
REQ-026 SHALL clear output_valid_o after a beat with output_ready_i=1 unless a new beat is loaded in the same cycle; simultaneous drain and load gives full throughput of 1 beat/cycle.
REQ-027 SHALL hold output_data_o and output_valid_o stable while output_valid_o=1 and output_ready_i=0.
REQ-028 SHALL let a pending output drain after the return to IDLE; a new start does not disturb it.
REQ-029 SHALL pulse cmd_done_o in the cycle the sample with index cfg_len_i is accepted; cfg_len_i=0 means a single sample.
REQ-030 SHALL increment counter_val_o by 1 on each accepted hit; it wraps modulo 2^TRANS_SIZE when the event is disabled.
REQ-031 SHALL, when en_counter=1, target != 0, and an accepted hit finds count == target-1, pulse act_event_o for one cycle (registered, the cycle after acceptance) and set the count to 0.
REQ-032 SHALL never raise act_event_o when target=0.
REQ-033 SHALL compute the sample index in TRANS_SIZE bits with no overflow, since cfg_len_i ≤ 2^TRANS_SIZE-1.

Reset
REQ-034 SHALL, while resetn_i=0, set state=IDLE and set output_valid_o, output_data_o, counter_val_o, act_event_o, cmd_done_o, input_ready_o and all latched configuration to 0.
REQ-035 SHALL, on reset asserted mid-transfer, abort immediately and discard the pending output; the next start behaves as from power-up.

Verification
REQ-036 SHALL cover: unsigned byte, threshold 0x10, len 3, samples 0x0F,0x10,0x11,0xFF, ready always 1 -> outputs 0,0,1,1 one cycle after each accept; done with the 4th accept; count 2.
REQ-037 SHALL cover: signed byte, threshold 0, samples 0x80,0x7F -> outputs 0,1; unsigned run of the same samples -> 1,1.
REQ-038 SHALL cover: out_enable=1, output_ready_i held 0 for 5 cycles after the first beat -> input_ready_o=0 and output stable for those cycles, then 1 beat/cycle.
REQ-039 SHALL cover: en_counter=1, target 2, 5 consecutive hits -> act_event_o pulses after hits 2 and 4; counter_val_o ends at 1.
REQ-040 SHALL cover: out_enable=0, len 7 -> no output_valid_o; 8 samples accepted back-to-back; done on the 8th.
REQ-041 SHALL cover: resetn_i asserted after 2 of 4 samples with an output pending -> all outputs 0; a new start with len 0 completes after 1 sample.
